// File: rtl/alu_8bit_seq_if.sv
// Request/response bundle for alu_8bit_seq: the master drives requests and
// consumes responses, the slave is the ALU front end.
interface alu_8bit_seq_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_select;
  logic             req_c;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_select, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_carry, rsp_zero, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_select, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_carry, rsp_zero, rsp_ovf
  );
endinterface

// File: rtl/alu_8bit_seq.sv
// Sequential request/response front end for the 8-bit add/subtract ALU.
// Define ALU_8BIT_SEQ_FLAGS_EN to build the carry/zero/overflow flag registers.
module alu_8bit_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_8bit_seq_if.slave    bus,
    output logic [CNT_W-1:0] op_count,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and payload is held while valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             req_ready, rsp_valid;
    logic [WIDTH-1:0] a_q, b_q, y_q, y_d;
    logic             sel_q, c_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) state_d = EXEC;
            end
            EXEC: state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sel_q <= 1'b0;
            c_q   <= 1'b0;
        end else if (state_q == IDLE && bus.req_valid) begin
            a_q   <= bus.req_a;
            b_q   <= bus.req_b;
            sel_q <= bus.req_select;
            c_q   <= bus.req_c;
        end
    end

`ifdef ALU_8BIT_SEQ_FLAGS_EN
    logic [WIDTH:0] res9;
    logic           carry_d, ovf_d;
    logic           carry_q, zero_q, ovf_q;

    // Subtract as A + ~B + 1 so bit 8 is the inverted borrow.
    always_comb begin
        if (sel_q) res9 = {1'b0, a_q} + {1'b0, b_q};
        else       res9 = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
        y_d     = res9[WIDTH-1:0];
        carry_d = sel_q ? res9[WIDTH] : ~res9[WIDTH];
        if (sel_q) ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (y_d[WIDTH-1] != a_q[WIDTH-1]);
        else       ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (y_d[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == EXEC) begin
            carry_q <= c_q & carry_d;
            zero_q  <= c_q ? (y_d == '0) : 1'b1;
            ovf_q   <= c_q & ovf_d;
        end
    end

    assign bus.rsp_carry = carry_q;
    assign bus.rsp_zero  = zero_q;
    assign bus.rsp_ovf   = ovf_q;
`else
    always_comb begin
        if (sel_q) y_d = a_q + b_q;
        else       y_d = a_q - b_q;
    end

    assign bus.rsp_carry = 1'b0;
    assign bus.rsp_zero  = 1'b0;
    assign bus.rsp_ovf   = 1'b0;
`endif

    // A disabled operation still produces a (zero) response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  y_q <= '0;
        else if (state_q == EXEC) y_q <= c_q ? y_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   op_count <= '0;
        else if (state_q == RESP && bus.rsp_ready) op_count <= op_count + CNT_W'(1);
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_y     = y_q;
    assign dbg_state     = state_q;

endmodule
